// File: rtl/ufir_cubico_pkg.sv
// Shared types and helpers for the cubic UFIR sequencer.
package ufir_cubico_pkg;

  typedef enum logic {IDLE, RUN} sched_state_t;

  localparam int DW = 16;

  typedef logic signed [DW-1:0] sample_t;

  function automatic int phase_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ufir_cubico_sched.sv
// Sequencer for the overclocked cubic UFIR datapath: latches one sample, steps the
// datapath through OVERCLOCK phases, then captures results once the horizon has filled.
module ufir_cubico_sched
  import ufir_cubico_pkg::*;
#(
  parameter int OVERCLOCK = 5,
  parameter int HORIZON   = 16,
  parameter int DW        = 16,
  localparam int PW       = phase_w(OVERCLOCK),
  localparam int CW       = phase_w(HORIZON + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic signed [DW-1:0] dp_sample,
  output logic                 dp_start,
  output logic                 dp_en,
  output logic [PW-1:0]        dp_phase,
  input  logic signed [DW-1:0] dp_y1,
  input  logic signed [DW-1:0] dp_y2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_y1,
  output logic signed [DW-1:0] out_y2,
  output logic                 warm
);

  localparam logic [PW-1:0] LastPhase = PW'(OVERCLOCK - 1);
  localparam logic [CW-1:0] HorizonCnt = CW'(HORIZON);
  localparam logic [CW-1:0] CaptureCnt = CW'(HORIZON - 1);

  sched_state_t          state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [CW-1:0]         count_q, count_d;
  logic signed [DW-1:0]  sample_q, sample_d;
  logic signed [DW-1:0]  y1_q, y1_d;
  logic signed [DW-1:0]  y2_q, y2_d;
  logic                  valid_q, valid_d;
  logic                  warm_q, warm_d;

  // The output register must be empty (or emptying) before a new sample starts,
  // so a capture can never collide with a pending result.
  assign in_ready  = clk_enable && !flush && (state_q == IDLE) && (!valid_q || out_ready);
  assign dp_en     = clk_enable && (state_q == RUN);
  assign dp_start  = dp_en && (phase_q == '0);
  assign dp_phase  = phase_q;
  assign dp_sample = sample_q;
  assign out_valid = valid_q;
  assign out_y1    = y1_q;
  assign out_y2    = y2_q;
  assign warm      = warm_q;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    count_d  = count_q;
    sample_d = sample_q;
    y1_d     = y1_q;
    y2_d     = y2_q;
    valid_d  = valid_q;
    if (clk_enable) begin
      if (flush) begin
        state_d = IDLE;
        phase_d = '0;
        count_d = '0;
        valid_d = 1'b0;
      end else begin
        if (valid_q && out_ready) valid_d = 1'b0;
        case (state_q)
          IDLE: begin
            if (in_valid && in_ready) begin
              sample_d = in_data;
              phase_d  = '0;
              state_d  = RUN;
            end
          end
          RUN: begin
            if (phase_q == LastPhase) begin
              phase_d = '0;
              state_d = IDLE;
              if (count_q >= CaptureCnt) begin
                y1_d    = dp_y1;
                y2_d    = dp_y2;
                valid_d = 1'b1;
              end
              if (count_q != HorizonCnt) count_d = count_q + 1'b1;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
    warm_d = (count_d == HorizonCnt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      count_q  <= '0;
      sample_q <= '0;
      y1_q     <= '0;
      y2_q     <= '0;
      valid_q  <= 1'b0;
      warm_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      count_q  <= count_d;
      sample_q <= sample_d;
      y1_q     <= y1_d;
      y2_q     <= y2_d;
      valid_q  <= valid_d;
      warm_q   <= warm_d;
    end
  end

endmodule

// File: tb/tb_ufir_cubico_sched.sv
// Scoreboard bench for ufir_cubico_sched with OVERCLOCK=5, HORIZON=4.
module tb_ufir_cubico_sched;

  localparam int OC = 5;
  localparam int HZ = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clkEnable = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [15:0] inData = '0;
  logic [15:0] dpSample;
  logic        dpStart;
  logic        dpEn;
  logic [2:0]  dpPhase;
  logic [15:0] dpY1 = '0;
  logic [15:0] dpY2 = '0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [15:0] outY1;
  logic [15:0] outY2;
  logic        warm;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cyc = 0;
  int          acceptCyc = 0;
  logic [31:0] expQ[$];

  ufir_cubico_sched #(.OVERCLOCK(OC), .HORIZON(HZ), .DW(16)) dut (
    .clk(clk), .reset(reset), .clk_enable(clkEnable), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .dp_sample(dpSample), .dp_start(dpStart), .dp_en(dpEn), .dp_phase(dpPhase),
    .dp_y1(dpY1), .dp_y2(dpY2),
    .out_valid(outValid), .out_ready(outReady), .out_y1(outY1), .out_y2(outY2),
    .warm(warm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected result from the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && outValid && outReady && clkEnable && !flush) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected output: got y1=0x%0h y2=0x%0h, expected none", outY1, outY2);
        end else begin
          e = expQ.pop_front();
          checkOutput("scoreboard out_y1", {16'h0, outY1}, {16'h0, e[31:16]});
          checkOutput("scoreboard out_y2", {16'h0, outY2}, {16'h0, e[15:0]});
        end
      end
    end
  end

  // Issues one sample and walks its phases; optionally freezes at phase 2 or aborts
  // at phase abortAt with a flush (abortRst=0) or an asynchronous reset (abortRst=1).
  task automatic applyStimulus(input logic [15:0] data, input logic [15:0] y1,
                               input logic [15:0] y2, input bit expOut, input int freeze,
                               input int abortAt, input bit abortRst);
    int startCyc;
    int p;
    inValid = 1'b1;
    inData  = data;
    dpY1    = y1;
    dpY2    = y2;
    #1;
    for (int k = 0; k < 40 && !inReady; k++) @(negedge clk);
    checkOutput("in_ready before accept", {31'h0, inReady}, 32'h1);
    if (!inReady) begin
      inValid = 1'b0;
      return;
    end
    startCyc  = cyc;
    acceptCyc = startCyc;
    if (expOut) expQ.push_back({y1, y2});
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("dp_sample", {16'h0, dpSample}, {16'h0, data});
    p = 0;
    while (p < OC) begin
      checkOutput("dp_phase", {29'h0, dpPhase}, p);
      checkOutput("dp_start", {31'h0, dpStart}, {31'h0, (p == 0)});
      checkOutput("dp_en", {31'h0, dpEn}, 32'h1);
      if (p == abortAt) begin
        if (abortRst) begin
          #2 reset = 1'b1;
          #1;
          checkOutput("reset dp_en", {31'h0, dpEn}, 32'h0);
          checkOutput("reset dp_start", {31'h0, dpStart}, 32'h0);
          checkOutput("reset dp_phase", {29'h0, dpPhase}, 32'h0);
          checkOutput("reset dp_sample", {16'h0, dpSample}, 32'h0);
          checkOutput("reset out_valid", {31'h0, outValid}, 32'h0);
          checkOutput("reset out_y1", {16'h0, outY1}, 32'h0);
          checkOutput("reset out_y2", {16'h0, outY2}, 32'h0);
          checkOutput("reset warm", {31'h0, warm}, 32'h0);
          @(negedge clk);
          reset = 1'b0;
        end else begin
          checkOutput("warm before flush", {31'h0, warm}, 32'h1);
          flush   = 1'b1;
          inValid = 1'b1;
          #1;
          checkOutput("in_ready during flush", {31'h0, inReady}, 32'h0);
          @(negedge clk);
          flush   = 1'b0;
          inValid = 1'b0;
          checkOutput("flush dp_en", {31'h0, dpEn}, 32'h0);
          checkOutput("flush dp_phase", {29'h0, dpPhase}, 32'h0);
          checkOutput("flush warm", {31'h0, warm}, 32'h0);
          checkOutput("flush out_valid", {31'h0, outValid}, 32'h0);
        end
        return;
      end
      if (p == 2 && freeze > 0) begin
        clkEnable = 1'b0;
        #1;
        checkOutput("freeze dp_en", {31'h0, dpEn}, 32'h0);
        for (int f = 0; f < freeze; f++) begin
          @(negedge clk);
          checkOutput("freeze dp_phase", {29'h0, dpPhase}, 32'h2);
          checkOutput("freeze dp_en", {31'h0, dpEn}, 32'h0);
          checkOutput("freeze in_ready", {31'h0, inReady}, 32'h0);
          checkOutput("freeze out_valid", {31'h0, outValid}, 32'h0);
        end
        clkEnable = 1'b1;
      end
      p++;
      if (p < OC) @(negedge clk);
    end
    @(negedge clk);
    checkOutput("idle dp_en", {31'h0, dpEn}, 32'h0);
    checkOutput("out_valid after sample", {31'h0, outValid}, {31'h0, expOut});
    checkOutput("latency", cyc - startCyc, 6 + freeze);
    if (expOut) checkOutput("warm with output", {31'h0, warm}, 32'h1);
  endtask

  initial begin
    int prev;
    repeat (2) @(negedge clk);
    checkOutput("reset dp_en", {31'h0, dpEn}, 32'h0);
    checkOutput("reset dp_start", {31'h0, dpStart}, 32'h0);
    checkOutput("reset dp_phase", {29'h0, dpPhase}, 32'h0);
    checkOutput("reset dp_sample", {16'h0, dpSample}, 32'h0);
    checkOutput("reset out_valid", {31'h0, outValid}, 32'h0);
    checkOutput("reset out_y1", {16'h0, outY1}, 32'h0);
    checkOutput("reset warm", {31'h0, warm}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single sample: no output before the horizon fills.
    applyStimulus(16'h1234, 16'h0055, 16'h0066, 1'b0, 0, -1, 1'b0);
    checkOutput("warm after 1 sample", {31'h0, warm}, 32'h0);

    // Restart warm-up, then four back-to-back samples.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(16'h0001, 16'h0100, 16'h0200, 1'b0, 0, -1, 1'b0);
    for (int s = 2; s <= 3; s++) begin
      prev = acceptCyc;
      applyStimulus(16'(s), 16'h0300, 16'h0400, 1'b0, 0, -1, 1'b0);
      checkOutput("accept spacing", acceptCyc - prev, 6);
    end
    prev = acceptCyc;
    applyStimulus(16'h0004, 16'hFFFB, 16'h0007, 1'b1, 0, -1, 1'b0);
    checkOutput("accept spacing", acceptCyc - prev, 6);
    checkOutput("out_y1 4th sample", {16'h0, outY1}, 32'h0000FFFB);
    checkOutput("out_y2 4th sample", {16'h0, outY2}, 32'h00000007);

    // Back-pressure: a full output register blocks the next sample.
    @(negedge clk);
    checkOutput("drained", {31'h0, outValid}, 32'h0);
    outReady = 1'b0;
    applyStimulus(16'h0AAA, 16'h1111, 16'h2222, 1'b1, 0, -1, 1'b0);
    inValid = 1'b1;
    inData  = 16'h0BBB;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("stall in_ready", {31'h0, inReady}, 32'h0);
      checkOutput("stall out_valid", {31'h0, outValid}, 32'h1);
      checkOutput("stall out_y1", {16'h0, outY1}, 32'h00001111);
      @(negedge clk);
    end
    outReady = 1'b1;
    applyStimulus(16'h0BBB, 16'h3333, 16'h4444, 1'b1, 0, -1, 1'b0);

    // Global enable dropped for three cycles at phase 2.
    applyStimulus(16'h0C0C, 16'h5555, 16'h6666, 1'b1, 3, -1, 1'b0);
    checkOutput("out_y1 after freeze", {16'h0, outY1}, 32'h00005555);

    // Flush mid-sample, then the horizon must refill before output resumes.
    applyStimulus(16'h0CCC, 16'h7070, 16'h0707, 1'b0, 0, 3, 1'b0);
    for (int s = 0; s < 3; s++)
      applyStimulus(16'h0D00 + 16'(s), 16'h1212, 16'h3434, 1'b0, 0, -1, 1'b0);
    applyStimulus(16'h0D03, 16'h7777, 16'h8888, 1'b1, 0, -1, 1'b0);

    // Asynchronous reset mid-RUN, then normal operation from scratch.
    applyStimulus(16'h0DDD, 16'h9999, 16'hAAAA, 1'b0, 0, 2, 1'b1);
    applyStimulus(16'h0EEE, 16'hBBBB, 16'hCCCC, 1'b0, 0, -1, 1'b0);
    checkOutput("warm after reset", {31'h0, warm}, 32'h0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
